// File: rtl/float_add_pipe_if.sv
// Handshake and data bundle for float_add_pipe.
//   master: producer/consumer side (drives operands and out_ready)
//   slave : the adder (drives in_ready, out_valid, result, sat)
// Signals:
//   in_valid/in_ready  - operand pair handshake
//   a_in/b_in          - operands, {exp, mant}, value = mant * 2^exp
//   out_valid/out_ready- result handshake
//   result/sat         - sum {exp, mant}; sat marks a clamped result
interface float_add_pipe_if #(
  parameter int unsigned EXP_W = 3,
  parameter int unsigned MAN_W = 5
);
  localparam int unsigned W = EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         sat;

  modport master (
    output in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, result, sat
  );

  modport slave (
    input  in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, result, sat
  );
endinterface

// File: rtl/float_add_pipe.sv
// float_add_pipe: 3-stage unsigned mini-float adder with valid/ready flow.
//   S1 compare/swap, S2 align, S3 add/normalise/saturate.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high
//   bus   - float_add_pipe_if.slave (operands in, result/sat out)
// Optional feature: define FLOAT_ADD_PIPE_ROUND_EN to round half up on the
// guard bit; otherwise the result is truncated and no guard bit is kept.
module float_add_pipe #(
  parameter int unsigned EXP_W = 3,
  parameter int unsigned MAN_W = 5
) (
  input  logic           clk,
  input  logic           reset,
  float_add_pipe_if.slave bus
);
  localparam int unsigned W    = EXP_W + MAN_W;
  localparam int unsigned EMAX = (1 << EXP_W) - 1;
`ifdef FLOAT_ADD_PIPE_ROUND_EN
  localparam int unsigned AL_W = MAN_W + 1;  // aligned mantissa incl. guard
`else
  localparam int unsigned AL_W = MAN_W;      // guard bit never needed
`endif

  // Whole pipeline advances unless the output register is held
  logic adv_c;

  // S1 registers: ordered operands
  logic         v1_q, v1_d;
  logic [W-1:0] g_q, g_d;
  logic [W-1:0] l_q, l_d;

  // S2 registers: larger exponent/mantissa and aligned smaller mantissa
  logic             v2_q, v2_d;
  logic [EXP_W-1:0] e2_q, e2_d;
  logic [MAN_W-1:0] m2_q, m2_d;
  logic [AL_W-1:0]  al_q, al_d;

  // S3 registers: output
  logic         ov_q, ov_d;
  logic [W-1:0] res_q, res_d;
  logic         sat_q, sat_d;

  logic [EXP_W-1:0] d_c;
  logic [EXP_W:0]   exp_c;
  logic [MAN_W-1:0] mant_c;
`ifdef FLOAT_ADD_PIPE_ROUND_EN
  logic [MAN_W+1:0] sum_c;
  logic             rbit_c;
`else
  logic [MAN_W:0]   sum_c;
`endif

  assign adv_c         = !(ov_q && !bus.out_ready);
  assign bus.in_ready  = adv_c;
  assign bus.out_valid = ov_q;
  assign bus.result    = res_q;
  assign bus.sat       = sat_q;

  // S1: larger {exp, mant} becomes G; ties keep A as G
  always_comb begin
    v1_d = bus.in_valid;
    g_d  = bus.a_in;
    l_d  = bus.b_in;
    if (bus.a_in < bus.b_in) begin
      g_d = bus.b_in;
      l_d = bus.a_in;
    end
  end

  // S2: shift the smaller mantissa right by the exponent difference
  always_comb begin
    v2_d = v1_q;
    e2_d = g_q[W-1:MAN_W];
    m2_d = g_q[MAN_W-1:0];
    d_c  = g_q[W-1:MAN_W] - l_q[W-1:MAN_W];
    al_d = '0;
`ifdef FLOAT_ADD_PIPE_ROUND_EN
    if (32'(d_c) <= MAN_W) al_d = {l_q[MAN_W-1:0], 1'b0} >> d_c;
`else
    // Upper bits of {mantL, 0} >> d equal mantL >> d
    if (32'(d_c) < MAN_W) al_d = l_q[MAN_W-1:0] >> d_c;
`endif
  end

  // S3: add, normalise on carry-out, optional rounding, saturate
  always_comb begin
    exp_c  = {1'b0, e2_q};
    mant_c = '0;
`ifdef FLOAT_ADD_PIPE_ROUND_EN
    sum_c  = {1'b0, m2_q, 1'b0} + {1'b0, al_q};
    rbit_c = sum_c[0];
    if (sum_c[MAN_W+1]) begin
      mant_c = sum_c[MAN_W+1:2];
      rbit_c = sum_c[1];
      exp_c  = exp_c + {{EXP_W{1'b0}}, 1'b1};
    end else begin
      mant_c = sum_c[MAN_W:1];
    end
    if (rbit_c) begin
      if (&mant_c) begin
        // Rounding carried out of the mantissa: renormalise
        mant_c = {1'b1, {(MAN_W-1){1'b0}}};
        exp_c  = exp_c + {{EXP_W{1'b0}}, 1'b1};
      end else begin
        mant_c = mant_c + {{(MAN_W-1){1'b0}}, 1'b1};
      end
    end
`else
    sum_c = {1'b0, m2_q} + {1'b0, al_q};
    if (sum_c[MAN_W]) begin
      mant_c = sum_c[MAN_W:1];
      exp_c  = exp_c + {{EXP_W{1'b0}}, 1'b1};
    end else begin
      mant_c = sum_c[MAN_W-1:0];
    end
`endif
    ov_d  = v2_q;
    res_d = res_q;
    sat_d = sat_q;
    if (v2_q) begin
      if (32'(exp_c) > EMAX) begin
        res_d = '1;
        sat_d = 1'b1;
      end else begin
        res_d = {exp_c[EXP_W-1:0], mant_c};
        sat_d = 1'b0;
      end
    end
  end

  // Stage registers; reset drops everything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q  <= 1'b0;
      g_q   <= '0;
      l_q   <= '0;
      v2_q  <= 1'b0;
      e2_q  <= '0;
      m2_q  <= '0;
      al_q  <= '0;
      ov_q  <= 1'b0;
      res_q <= '0;
      sat_q <= 1'b0;
    end else if (adv_c) begin
      v1_q  <= v1_d;
      g_q   <= g_d;
      l_q   <= l_d;
      v2_q  <= v2_d;
      e2_q  <= e2_d;
      m2_q  <= m2_d;
      al_q  <= al_d;
      ov_q  <= ov_d;
      res_q <= res_d;
      sat_q <= sat_d;
    end
  end
endmodule

// File: doc/float_add_pipe.md
FLOAT_ADD_PIPE -- requirements
Module: float_add_pipe

Interface
REQ-001 Parameter EXP_W, default 3: exponent field width; legal range 2..6.
REQ-002 Parameter MAN_W, default 5: mantissa field width; legal range 3..16.
REQ-003 Port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1 bit: operand pair a_in/b_in is valid this cycle.
REQ-006 Port in_ready, output, 1 bit: block accepts an operand pair this cycle.
REQ-007 Port a_in, input, EXP_W+MAN_W bits: operand A, {exp, mant}, unsigned, value = mant * 2^exp.
REQ-008 Port b_in, input, EXP_W+MAN_W bits: operand B, same format as a_in.
REQ-009 Port out_valid, output, 1 bit: result/sat are valid this cycle.
REQ-010 Port out_ready, input, 1 bit: consumer accepts the result this cycle.
REQ-011 Port result, output, EXP_W+MAN_W bits: sum, {exp, mant}.
REQ-012 Port sat, output, 1 bit: result was clamped to the maximum code.

Function
REQ-013 The block SHALL be a 3-stage pipeline: S1 compare/swap, S2 align, S3 add/normalise/saturate; latency from input handshake to out_valid is exactly 3 cycles when not stalled.
REQ-014 A transfer SHALL occur on an edge where in_valid && in_ready; an output transfer SHALL occur on an edge where out_valid && out_ready.
REQ-015 in_ready SHALL equal !(out_valid && !out_ready); when stalled, all stages hold, and no data is lost or duplicated.
REQ-016 Throughput SHALL be one result per cycle while out_ready is held at 1; bubbles (in_valid=0) propagate as invalid stages.
REQ-017 S1 SHALL order operands so that the larger operand by {exp, mant} is G and the other is L; when the operands are equal, A is G.
REQ-018 S2 SHALL compute d = expG - expL and form the aligned value {mantL, 1'b0} >> d (MAN_W+1 bits, LSB = guard); for d > MAN_W, the aligned value SHALL be 0.
REQ-019 S3 SHALL form S = {mantG, 1'b0} + aligned (MAN_W+2 bits).
REQ-020 If S[MAN_W+1] = 1: mant = S[MAN_W+1:2], rbit = S[1], exp = expG+1; otherwise mant = S[MAN_W:1], rbit = S[0], exp = expG.
REQ-021 If exp exceeds 2^EXP_W-1, result SHALL be all ones (max exp, max mant) and sat = 1; otherwise sat = 0.
REQ-022 result and sat SHALL hold stable while out_valid && !out_ready.
REQ-023 The design SHALL be fully combinational within each stage, with registers only between stages; there are no multi-cycle paths.

Reset
REQ-024 While reset = 1 at an edge, all stage valid bits SHALL clear; out_valid = 0, result = 0, sat = 0; in_ready = 1 on the following cycle.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight operands, which are never output; a pair presented on the reset edge is not accepted.

Configuration
REQ-026 Macro FLOAT_ADD_PIPE_ROUND_EN defined: S3 SHALL add rbit to mant (round half up).
REQ-027 If this rounding overflows mant, S3 SHALL set mant = 1 followed by MAN_W-1 zeros and increment exp by 1, then apply REQ-021.
REQ-028 Macro undefined: rbit SHALL be ignored (truncation); no rounding logic is synthesised.

Verification (EXP_W=3, MAN_W=5)
REQ-029 Same exponent, no carry: a=0x45, b=0x43 -> result 0x48, sat 0, out_valid exactly 3 cycles after acceptance.
REQ-030 Carry normalise: a=0x34, b=0x34 -> result 0x54, sat 0.
REQ-031 Align with guard: a=0x70, b=0x23 -> result 0x71 with ROUND_EN, 0x70 without; b=0x70, a=0x23 -> identical results.
REQ-032 Saturation: a=0xFF, b=0xFF -> result 0xFF, sat 1; large shift: a=0xE1, b=0x01 -> 0xE1, sat 0.
REQ-033 Backpressure: stream 5 pairs with out_ready=0 for cycles 4-8 -> in_ready low during the stall, all 5 results delivered in order, none duplicated.
REQ-034 Reset mid-stream: assert reset with 2 pairs in flight -> no out_valid for those pairs; the next accepted pair emerges correctly after 3 cycles.
